// File: rtl/uart_tx_buffer.sv
// Byte FIFO and launch sequencer feeding a UART transmitter through its toggle-style
// start input and busy output, with a stop-bit guard interval and an acknowledge timeout.
module uart_tx_buffer #(
    parameter int DEPTH          = 16,
    parameter int NO_OF_DATABITS = 8,
    parameter int GUARD_CYCLES   = 10417,
    parameter int BUSY_TIMEOUT   = 16,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [NO_OF_DATABITS-1:0] wr_data,
    output logic                      full,
    output logic [ADDR_W:0]           count,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [NO_OF_DATABITS-1:0] tx_data,
    output logic                      overflow,
    output logic                      timeout_err
);

    localparam int TIMER_MAX = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] GUARD_LOAD   = TIMER_W'(GUARD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]    DEPTH_CNT    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GUARD
    } state_e;

    state_e                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]           count_q, count_d;
    logic                      full_q, full_d;
    logic                      tx_start_q, tx_start_d;
    logic [NO_OF_DATABITS-1:0] tx_data_q, tx_data_d;
    logic                      overflow_q, overflow_d;
    logic                      timeout_q, timeout_d;
    logic                      push, pop;

    logic [NO_OF_DATABITS-1:0] mem [DEPTH];

    // Launch sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        timeout_d  = timeout_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    tx_data_d  = mem[rd_ptr_q];
                    tx_start_d = ~tx_start_q;
                    timer_d    = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Unacknowledged byte is dropped; the guard still runs before the next launch.
                    timeout_d = 1'b1;
                    timer_d   = GUARD_LOAD;
                    state_d   = GUARD;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    timer_d = GUARD_LOAD;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a write against a full buffer is dropped even if a pop frees a slot.
    always_comb begin
        push       = wr_en && !full_q;
        wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
        else if (!push && pop) count_d = count_q - (ADDR_W + 1)'(1);
        full_d     = (count_d == DEPTH_CNT);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign full        = full_q;
    assign count       = count_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a behavioural transmitter that raises busy
// 3 cycles after each start toggle and holds it for 50 cycles.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic [4:0] count;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       overflow;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       model_en = 1'b1;
    logic       prev_start = 1'b0;
    logic       pending = 1'b0;
    int         rise_cnt = 0;
    int         hi_cnt = 0;
    int         viol = 0;
    logic [7:0] rx_q [$];

    uart_tx_buffer #(
        .DEPTH(16),
        .NO_OF_DATABITS(8),
        .GUARD_CYCLES(4),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .count(count),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model, shares the reset; records every launched byte.
    always @(negedge clk) begin
        if (reset) begin
            prev_start = tx_start;
            pending    = 1'b0;
            tx_busy    = 1'b0;
            hi_cnt     = 0;
        end else if (tx_start !== prev_start) begin
            prev_start = tx_start;
            rx_q.push_back(tx_data);
            if (tx_busy || pending) viol++;
            if (model_en) begin
                pending  = 1'b1;
                rise_cnt = 2;
            end
        end else if (pending) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                pending = 1'b0;
                tx_busy = 1'b1;
                hi_cnt  = 50;
            end
        end else if (tx_busy) begin
            hi_cnt--;
            if (hi_cnt == 0) tx_busy = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        int n = 0;
        while (tx_busy !== val && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (tx_busy !== val) begin
            errors++;
            $display("FAIL %s: tx_busy=%b after %0d cycles, wanted %b", name, tx_busy, budget, val);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int   quiet = 0;
        int   n = 0;
        logic last = tx_start;
        while (quiet < 25 && n < budget) begin
            step();
            n++;
            if (tx_busy || count != 5'd0 || tx_start !== last) quiet = 0;
            else quiet++;
            last = tx_start;
        end
        checks++;
        if (quiet < 25) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles (count=%0d busy=%b)", name, budget, count, tx_busy);
        end
    endtask

    task automatic test_reset();
        int   base;
        logic moved = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({full, count, tx_start, tx_data, overflow, timeout_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values: got full=%b count=%0d start=%b data=%h ovf=%b to=%b, want all 0",
                     full, count, tx_start, tx_data, overflow, timeout_err);
        end
        base = rx_q.size();
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        wr_en = 1'b0;
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_prelaunch: got start=%b data=%h, want 1/11", tx_start, tx_data);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({full, count, tx_start, tx_data, overflow, timeout_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_async: got full=%b count=%0d start=%b data=%h ovf=%b to=%b, want all 0",
                     full, count, tx_start, tx_data, overflow, timeout_err);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_start !== 1'b0) moved = 1'b1;
        end
        checks++;
        if (moved || rx_q.size() != base + 1) begin
            errors++;
            $display("FAIL reset_quiet: moved=%b launches=%0d, want 0/1", moved, rx_q.size() - base);
        end
    endtask

    task automatic test_single_byte();
        int base = rx_q.size();
        int t0;
        int t1;
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got count=%0d start=%b, want 1/0", count, tx_start);
        end
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_launch: got start=%b data=%h count=%0d, want 1/a5/0", tx_start, tx_data, count);
        end
        wr_en = 1'b1; wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        wait_busy(1'b1, 20, "single_busy_rise");
        checks++;
        if (tx_data !== 8'hA5 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_hold: got data=%h count=%0d, want a5/1", tx_data, count);
        end
        wait_busy(1'b0, 100, "single_busy_fall");
        t0 = cyc;
        for (int n = 0; n < 30 && tx_start === 1'b1; n++) step();
        t1 = cyc;
        checks++;
        if (t1 - t0 !== 6) begin
            errors++;
            $display("FAIL single_spacing: got %0d cycles busy-fall to launch, want 6", t1 - t0);
        end
        checks++;
        if (tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL single_second: got data=%h, want 5a", tx_data);
        end
        wait_idle(300, "single_drain");
        checks++;
        if (rx_q.size() != base + 2 || rx_q[base] !== 8'hA5 || rx_q[base+1] !== 8'h5A) begin
            errors++;
            $display("FAIL single_rx: got %0d bytes, want a5,5a", rx_q.size() - base);
        end
    endtask

    task automatic test_burst_overflow();
        int         base = rx_q.size();
        logic [4:0] peak = 5'd0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_pre_ovf: got %b, want 0", overflow);
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            if (count > peak) peak = count;
        end
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1 || peak !== 5'd16) begin
            errors++;
            $display("FAIL burst_full: got count=%0d full=%b ovf=%b peak=%0d, want 16/1/1/16",
                     count, full, overflow, peak);
        end
        wait_idle(3000, "burst_drain");
        checks++;
        if (rx_q.size() != base + 17 || full !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_rx_count: got %0d bytes full=%b ovf=%b, want 17/0/1",
                     rx_q.size() - base, full, overflow);
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (rx_q[base+i] !== 8'(i)) begin
                errors++;
                $display("FAIL burst_rx[%0d]: got %h, want %h", i, rx_q[base+i], 8'(i));
            end
        end
    endtask

    task automatic test_simultaneous_wrap();
        int   base = rx_q.size();
        int   n = 0;
        logic last = tx_start;
        wr_en = 1'b1; wr_data = 8'h40;
        step();
        wr_data = 8'h41;
        step();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd1 || tx_start === last || tx_data !== 8'h40) begin
            errors++;
            $display("FAIL simul_count: got count=%0d start=%b data=%h, want 1/toggled/40", count, tx_start, tx_data);
        end
        for (int k = 0; k < 4000 && n < 40; k++) begin
            if (!full) begin
                wr_en = 1'b1; wr_data = 8'h80 + 8'(n);
                n++;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        wait_idle(3000, "simul_drain");
        checks++;
        if (rx_q.size() != base + 42) begin
            errors++;
            $display("FAIL simul_rx_count: got %0d bytes, want 42", rx_q.size() - base);
        end
        for (int i = 0; i < 42; i++) begin
            logic [7:0] exp;
            exp = (i == 0) ? 8'h40 : (i == 1) ? 8'h41 : 8'h80 + 8'(i - 2);
            checks++;
            if (rx_q[base+i] !== exp) begin
                errors++;
                $display("FAIL simul_rx[%0d]: got %h, want %h", i, rx_q[base+i], exp);
            end
        end
    endtask

    task automatic test_timeout();
        int   base = rx_q.size();
        int   k;
        int   t_to = -1;
        int   t_l = -1;
        logic last = tx_start;
        model_en = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_data = 8'h3D;
        step();
        wr_en = 1'b0;
        k = cyc;
        checks++;
        if (tx_start === last || tx_data !== 8'h3C || timeout_err !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL timeout_launch: got start=%b data=%h to=%b count=%0d, want toggled/3c/0/1",
                     tx_start, tx_data, timeout_err, count);
        end
        last = tx_start;
        for (int n = 0; n < 40 && t_l < 0; n++) begin
            step();
            if (timeout_err === 1'b1 && t_to < 0) begin
                t_to = cyc;
                model_en = 1'b1;
            end
            if (tx_start !== last) t_l = cyc;
        end
        checks++;
        if (t_to - k !== 16) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, want 16", t_to - k);
        end
        checks++;
        if (t_l - k !== 21 || tx_data !== 8'h3D) begin
            errors++;
            $display("FAIL timeout_relaunch: got %0d cycles data=%h, want 21/3d", t_l - k, tx_data);
        end
        wait_idle(300, "timeout_drain");
        checks++;
        if (rx_q.size() != base + 2 || rx_q[base] !== 8'h3C || rx_q[base+1] !== 8'h3D || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rx: got %0d bytes to=%b, want 3c,3d sticky 1", rx_q.size() - base, timeout_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   base;
        logic moved = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        wait_busy(1'b1, 20, "midreset_busy");
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL midreset_queued: got count=%0d, want 5", count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({full, count, tx_start, tx_data, overflow, timeout_err} !== 17'd0) begin
            errors++;
            $display("FAIL midreset_clear: got full=%b count=%0d start=%b data=%h ovf=%b to=%b, want all 0",
                     full, count, tx_start, tx_data, overflow, timeout_err);
        end
        step();
        reset = 1'b0;
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_start !== 1'b0 || count !== 5'd0) moved = 1'b1;
        end
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        checks++;
        if (moved || count !== 5'd1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: moved=%b count=%0d start=%b, want 0/1/0", moved, count, tx_start);
        end
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h77 || count !== 5'd0) begin
            errors++;
            $display("FAIL midreset_fresh: got start=%b data=%h count=%0d, want 1/77/0", tx_start, tx_data, count);
        end
        wait_idle(300, "midreset_drain");
        checks++;
        if (rx_q.size() != base + 1 || rx_q[base] !== 8'h77) begin
            errors++;
            $display("FAIL midreset_rx: got %0d bytes, want single 77", rx_q.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_simultaneous_wrap();
        test_timeout();
        test_reset_mid_frame();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL launch_while_busy: got %0d launches during busy, want 0", viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
